// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg -- shared types and constants for the counter sequencing controller.
//   state_t      : controller states IDLE / ARMED / RUN / DONE
//   RST_*        : values every register returns to under reset
//   is_terminal  : true when the count has reached the configured limit
// Optional feature macro used by this slice: CNT_SEQ_PRESCALE_EN.
package cnt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam state_t RST_STATE    = IDLE;
  localparam logic   RST_TICK     = 1'b0;
  localparam logic   RST_PERIODIC = 1'b0;

  // Callers widen both operands to 32 bits so one function serves any WIDTH.
  function automatic logic is_terminal(input logic [31:0] count, input logic [31:0] limit);
    return count == limit;
  endfunction

endpackage

// File: rtl/cnt_seq_prescaler.sv
// cnt_seq_prescaler -- clock divider that gates the counter steps.
// Only present when CNT_SEQ_PRESCALE_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : count prescaler cycles (controller is running)
//   reload     : force the prescaler back to 0 (not running / start / stop)
//   presc      : divide ratio minus one; a step happens every presc+1 clocks
//   step       : one-cycle pulse on the prescaler terminal cycle
`ifdef CNT_SEQ_PRESCALE_EN
module cnt_seq_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               reload,
  input  logic [PRESC_W-1:0] presc,
  output logic               step
);

  logic [PRESC_W-1:0] cnt_q;

  assign step = enable && !reload && (cnt_q == presc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (reload) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= step ? '0 : cnt_q + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl -- sequencing controller for a free-running up-counter.
// Holds a terminal-count configuration, starts/stops the count and emits a
// registered one-cycle tick at every terminal count, one-shot or periodic.
// Optional feature: CNT_SEQ_PRESCALE_EN adds cfg_presc and steps the counter
// only every cfg_presc+1 clocks.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   cfg_valid/cfg_ready : configuration handshake
//   cfg_limit    : terminal count (period = limit+1 steps)
//   cfg_periodic : 1 = wrap and continue, 0 = one-shot
//   cfg_presc    : prescale ratio minus one (CNT_SEQ_PRESCALE_EN only)
//   start, stop  : run control; stop wins over start
//   count        : current count value
//   busy, done   : level status (RUN / DONE)
//   tick         : registered pulse at each terminal count
//   dbg_state    : current controller state
// Handshake: the configuration transfers on any rising edge where
// cfg_valid && cfg_ready; cfg_ready depends only on state (low in RUN), so the
// master may hold cfg_valid and its payload until it sees cfg_ready.
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_limit,
  input  logic               cfg_periodic,
`ifdef CNT_SEQ_PRESCALE_EN
  input  logic [PRESC_W-1:0] cfg_presc,
`endif
  input  logic               start,
  input  logic               stop,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               tick,
  output logic               done,
  output state_t             dbg_state
);

  if (WIDTH < 2) begin : g_width_chk
    $error("cnt_seq_ctrl: WIDTH must be >= 2");
  end
  if (PRESC_W < 1) begin : g_presc_chk
    $error("cnt_seq_ctrl: PRESC_W must be >= 1");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q;
  logic             periodic_q;
  logic             tick_q, tick_d;
  logic             cfg_hs;
  logic             step;
  logic             terminal;

  assign cfg_hs = cfg_valid && (state_q != RUN);

`ifdef CNT_SEQ_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else if (cfg_hs) begin
      presc_q <= cfg_presc;
    end
  end

  // Held in reload whenever not running, so every start, stop and return to
  // RUN begins a fresh prescaler period.
  cnt_seq_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk    (clk),
    .rst_n  (reset),
    .enable (state_q == RUN),
    .reload (state_q != RUN),
    .presc  (presc_q),
    .step   (step)
  );
`else
  assign step = 1'b1;
`endif

  assign terminal = step && is_terminal(32'(count_q), 32'(limit_q));

  always_comb begin
    state_d = state_q;
    count_d = '0;
    tick_d  = RST_TICK;
    case (state_q)
      IDLE: begin
        if (cfg_hs) state_d = ARMED;
      end
      ARMED, DONE: begin
        // A simultaneous cfg is latched below, so start runs with the new limit.
        if (stop)        state_d = ARMED;
        else if (start)  state_d = RUN;
        else if (cfg_hs) state_d = ARMED;
      end
      RUN: begin
        if (stop) begin
          state_d = ARMED;
        end else if (terminal) begin
          tick_d = 1'b1;
          if (!periodic_q) state_d = DONE;
        end else if (step) begin
          count_d = count_q + 1'b1;
        end else begin
          count_d = count_q;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RST_STATE;
      count_q    <= '0;
      tick_q     <= RST_TICK;
      limit_q    <= '0;
      periodic_q <= RST_PERIODIC;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      if (cfg_hs) begin
        limit_q    <= cfg_limit;
        periodic_q <= cfg_periodic;
      end
    end
  end

  assign cfg_ready = (state_q != RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign tick      = tick_q;
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl -- directed and randomized bench for cnt_seq_ctrl.
// Reference model tracks the run by elapsed clocks since start and derives
// count/tick from modulo arithmetic on the configured period.
module tb_cnt_seq_ctrl;
  import cnt_seq_pkg::*;

  localparam int WIDTH   = 8;
  localparam int PRESC_W = 4;
`ifdef CNT_SEQ_PRESCALE_EN
  localparam int SP6 = 6;
`else
  localparam int SP6 = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             cfg_valid = 1'b0;
  logic [WIDTH-1:0] cfg_limit = '0;
  logic             cfg_periodic = 1'b0;
`ifdef CNT_SEQ_PRESCALE_EN
  logic [PRESC_W-1:0] cfg_presc = '0;
`endif
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             cfg_ready, busy, tick, done;
  logic [WIDTH-1:0] count;
  state_t           dbg_state;

  cnt_seq_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_limit    (cfg_limit),
    .cfg_periodic (cfg_periodic),
`ifdef CNT_SEQ_PRESCALE_EN
    .cfg_presc    (cfg_presc),
`endif
    .start        (start),
    .stop         (stop),
    .count        (count),
    .busy         (busy),
    .tick         (tick),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  state_t m_state = IDLE;
  int     m_elapsed = 0;
  int     m_lim = 0;
  int     m_pre = 0;
  bit     m_per = 1'b0;
  bit     m_tick = 1'b0;

  function automatic int m_count();
    if (m_state != RUN) return 0;
    return (m_elapsed / (m_pre + 1)) % (m_lim + 1);
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit hs;
    if (!reset) begin
      m_state = IDLE; m_elapsed = 0; m_lim = 0; m_pre = 0; m_per = 0; m_tick = 0;
    end else begin
      hs = cfg_valid && (m_state != RUN);
      m_tick = 0;
      if (m_state == RUN) begin
        if (stop) m_state = ARMED;
        else begin
          m_elapsed++;
          if (m_elapsed % ((m_pre + 1) * (m_lim + 1)) == 0) begin
            m_tick = 1;
            if (!m_per) m_state = DONE;
          end
        end
      end else begin
        if (hs) begin
          m_lim = int'(cfg_limit);
          m_per = cfg_periodic;
`ifdef CNT_SEQ_PRESCALE_EN
          m_pre = int'(cfg_presc);
`endif
        end
        if (m_state == IDLE) begin
          if (hs) m_state = ARMED;
        end else if (stop) m_state = ARMED;
        else if (start) begin
          m_state = RUN;
          m_elapsed = 0;
        end else if (hs) m_state = ARMED;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (reset) begin
      check("mdl_count", 32'(count), 32'(m_count()));
      check("mdl_tick", 32'(tick), 32'(m_tick));
      check("mdl_busy", 32'(busy), 32'(m_state == RUN));
      check("mdl_done", 32'(done), 32'(m_state == DONE));
      check("mdl_cfg_ready", 32'(cfg_ready), 32'(m_state != RUN));
      check("mdl_state", 32'(dbg_state), 32'(m_state));
    end
  end

  // ---------------- driver tasks (start and end at a falling edge) ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_cfg(input int lim, input bit per, input int pre);
    cfg_valid = 1'b1;
    cfg_limit = WIDTH'(lim);
    cfg_periodic = per;
`ifdef CNT_SEQ_PRESCALE_EN
    cfg_presc = PRESC_W'(pre);
`else
    if (pre != 0) $display("note: prescale %0d ignored in this build", pre);
`endif
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ticks;
    reset = 1'b0;
    wait_cyc(3);
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    reset = 1'b1;
    wait_cyc(1);

    // periodic limit=3: counts 0,1,2,3,0 and a tick every 4 clocks
    do_cfg(3, 1'b1, 0);
    check("t2_armed", 32'(dbg_state), 32'(ARMED));
    exp_q = {8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    pulse_start();
    for (int j = 0; j < 20; j++) begin
      check("t2_busy", 32'(busy), 1);
      if (exp_q.size() > 0) check("t2_count", 32'(count), 32'(exp_q.pop_front()));
      check("t2_tick", 32'(tick), 32'(j > 0 && j % 4 == 0));
      @(negedge clk);
    end
    do_stop();
    check("stop_busy", 32'(busy), 0);
    check("stop_count", 32'(count), 0);

    // one-shot limit=2, started twice
    do_cfg(2, 1'b0, 0);
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      ticks = 0;
      for (int j = 0; j < 8; j++) begin
        if (j == 3) begin
          check("t3_tick", 32'(tick), 1);
          check("t3_done", 32'(done), 1);
          check("t3_busy", 32'(busy), 0);
          check("t3_count", 32'(count), 0);
        end
        ticks += int'(tick);
        @(negedge clk);
      end
      check("t3_ticks", 32'(ticks), 1);
      check("t3_done_hold", 32'(done), 1);
    end

    // stop and start together at count==limit
    do_cfg(4, 1'b1, 0);
    pulse_start();
    wait_cyc(4);
    check("t4_count4", 32'(count), 4);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("t4_tick", 32'(tick), 0);
    check("t4_count", 32'(count), 0);
    check("t4_state", 32'(dbg_state), 32'(ARMED));
    check("t4_cfg_ready", 32'(cfg_ready), 1);

    // reach DONE with limit=0 one-shot, then cfg+start together
    do_cfg(0, 1'b0, 0);
    pulse_start();
    wait_cyc(1);
    check("t5_l0_tick", 32'(tick), 1);
    check("t5_l0_done", 32'(done), 1);
    wait_cyc(2);
    cfg_valid = 1'b1; cfg_limit = 8'd1; cfg_periodic = 1'b1; start = 1'b1;
`ifdef CNT_SEQ_PRESCALE_EN
    cfg_presc = '0;
`endif
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    check("t5_busy", 32'(busy), 1);
    check("t5_count", 32'(count), 0);
    for (int j = 0; j < 7; j++) begin
      check("t5_cfg_ready", 32'(cfg_ready), 0);
      check("t5_tick", 32'(tick), 32'(j > 0 && j % 2 == 0));
      @(negedge clk);
    end
    do_stop();

    // limit=1, presc=2 periodic: spacing depends on the prescale build
    do_cfg(1, 1'b1, 2);
    pulse_start();
    for (int j = 0; j <= 3 * SP6; j++) begin
      check("t6_tick", 32'(tick), 32'(j > 0 && j % SP6 == 0));
      @(negedge clk);
    end
    do_stop();

    // randomized traffic, checked by the compare process
    for (int i = 0; i < 4000; i++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) cfg_limit = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd254;
      else cfg_limit = 8'($urandom_range(0, 6));
      cfg_periodic = 1'($urandom_range(0, 1));
`ifdef CNT_SEQ_PRESCALE_EN
      cfg_presc = PRESC_W'($urandom_range(0, 3));
`endif
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      @(negedge clk);
    end
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;

    // asynchronous reset mid-run at count=5
    do_stop();
    do_cfg(9, 1'b1, 0);
    pulse_start();
    wait_cyc(5);
    check("t1_count5", 32'(count), 5);
    #2 reset = 1'b0;
    #1;
    check("t1_count", 32'(count), 0);
    check("t1_busy", 32'(busy), 0);
    check("t1_tick", 32'(tick), 0);
    check("t1_done", 32'(done), 0);
    check("t1_cfg_ready", 32'(cfg_ready), 1);
    check("t1_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    pulse_start();
    check("t1_start_ign_busy", 32'(busy), 0);
    check("t1_start_ign_state", 32'(dbg_state), 32'(IDLE));
    wait_cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
